oh_clockmux_seq: RTL and testbench
==================================

Name: oh_clockmux_seq

Overview:
- Break-before-make enable sequencer for an N-input one-hot clock mux.
- Accepts binary clock-select requests over a valid/ready handshake.
- Drives a registered one-hot enable vector and guarantees an all-zero enable gap of exactly DEAD cycles between deselecting one clock and selecting another.
- Sits in the clock/reset block beside the mux it feeds; runs on a free-running reference clock.

Parameters:
- N, 4, number of mux channels (>=2).
- DEAD, 2, dead cycles with en all-zero on every switch (>=1; DEAD=0 is a compile-time error).
- SW, $clog2(N)+1, width of req_sel; the extra bit allows out-of-range codes.

Ports:
- clk  input  1  reference clock; all logic on rising edge.
- nreset  input  1  synchronous active-low reset.
- req_valid  input  1  select request valid.
- req_sel  input  SW  requested channel, binary.
- req_ready  output  1  request can be accepted this cycle.
- en  output  N  one-hot (or all-zero) enable to the clock mux; registered.
- active  output  1  en is non-zero.
- active_sel  output  SW  index of the currently enabled channel; 0 when inactive.
- busy  output  1  switch in progress (equals ~req_ready).
- err  output  1  one-cycle pulse: an out-of-range request was accepted.

Behaviour:
- One clock (clk); reset is synchronous and active-low (nreset).
- Reset values (edge with nreset=0): en=0, active=0, active_sel=0, req_ready=1, busy=0, err=0, state=IDLE, dead counter=0.
- Reset mid-switch or while ON forces en=0 on that same edge. There is no dead-time guarantee across reset.
- Handshake: a request is accepted on a rising edge with req_valid=1 and req_ready=1. req_sel is sampled only at acceptance. Requests while req_ready=0 are ignored; the requester must hold req_valid.
- State IDLE (en=0, req_ready=1):
  - Accept with req_sel<N: latch target, load counter=DEAD, go to WAIT.
  - Accept with req_sel>=N: err=1 for one cycle, stay in IDLE.
- State WAIT (en=0, req_ready=0, busy=1):
  - Counter decrements each cycle.
  - On the edge where the counter reaches 1: en=(1<<target), active_sel=target, active=1, req_ready=1, go to ON.
- State ON (en one-hot, req_ready=1):
  - Accept with req_sel equal to active_sel: no change, no gap, no err.
  - Accept with a different in-range req_sel: en=0 on the acceptance edge, latch target, counter=DEAD, go to WAIT.
  - Accept with req_sel>=N: err pulse; en and state unchanged.
- Timing for a switch accepted at edge k:
  - en=0 from edge k through edge k+DEAD-1.
  - New en appears after edge k+DEAD.
  - en is zero for exactly DEAD cycles.
  - req_ready is low for exactly DEAD cycles.
- en is never multi-hot in any cycle. Only a register may drive en; no combinational path to en.
- err is valid only in the cycle after acceptance. It never coincides with a state change.
- active = |en. busy = ~req_ready.

Test Plan:
- Reset: hold nreset=0 for 3 cycles with req_valid=1, req_sel=2 -> en=0, req_ready=1, err=0 throughout; request not accepted.
- First select, N=4, DEAD=2: from IDLE accept req_sel=2 at edge k -> en=0 after edges k and k+1; en=4'b0100, active_sel=2, req_ready=1 after edge k+2.
- Switch: while ON at channel 2, accept req_sel=0 -> en=0 for exactly 2 cycles, then en=4'b0001. Check assertion: en never multi-hot, and no cycle with old and new bits adjacent without a gap.
- Same-channel request: while ON at channel 0, accept req_sel=0 -> en stays 4'b0001, req_ready stays 1, err=0.
- Out-of-range: accept req_sel=5 in IDLE and in ON -> err=1 for one cycle each; en unchanged.
- Reset mid-WAIT: nreset=0 one cycle after a switch is accepted -> en=0, state IDLE, req_ready=1. A subsequent req_sel=3 completes after DEAD cycles with en=4'b1000.

Source files
------------

// File: rtl/oh_clockmux_seq.sv
// Break-before-make enable sequencer for an N-input one-hot clock mux.
// Takes binary select requests over valid/ready and drives a registered
// one-hot enable. Every switch passes through exactly DEAD all-zero cycles.
module oh_clockmux_seq #(
    parameter int N    = 4,
    parameter int DEAD = 2,
    parameter int SW   = $clog2(N) + 1
) (
    input  logic          clk,
    input  logic          nreset,
    input  logic          req_valid,
    input  logic [SW-1:0] req_sel,
    output logic          req_ready,
    output logic [N-1:0]  en,
    output logic          active,
    output logic [SW-1:0] active_sel,
    output logic          busy,
    output logic          err
);

    localparam int CW = $clog2(DEAD + 1);

    // A zero dead time would remove the break-before-make gap entirely.
    if (DEAD < 1) begin : g_bad_dead
        $error("oh_clockmux_seq: DEAD must be at least 1");
    end
    if (N < 2) begin : g_bad_n
        $error("oh_clockmux_seq: N must be at least 2");
    end

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        ON   = 2'd2
    } state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [SW-1:0] target_q, target_d;
    logic [SW-1:0] asel_q, asel_d;
    logic [N-1:0]  en_q, en_d;
    logic          err_q, err_d;

    logic          accept;
    logic          inRange;

    assign accept  = req_valid & req_ready;
    assign inRange = (req_sel < SW'(N));

    // State and datapath registers; reset clears enables on the same edge.
    always_ff @(posedge clk) begin
        if (!nreset) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            target_q <= '0;
            asel_q   <= '0;
            en_q     <= '0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            target_q <= target_d;
            asel_q   <= asel_d;
            en_q     <= en_d;
            err_q    <= err_d;
        end
    end

    // Next-state logic: accept requests, count the dead gap, enable the target.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        target_d = target_q;
        asel_d   = asel_q;
        en_d     = en_q;
        err_d    = 1'b0;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    if (inRange) begin
                        target_d = req_sel;
                        cnt_d    = CW'(DEAD);
                        state_d  = WAIT;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            WAIT: begin
                if (cnt_q == CW'(1)) begin
                    en_d    = N'(1) << target_q;
                    asel_d  = target_q;
                    cnt_d   = '0;
                    state_d = ON;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            ON: begin
                if (accept) begin
                    if (!inRange) begin
                        err_d = 1'b1;
                    end else if (req_sel != asel_q) begin
                        en_d     = '0;
                        asel_d   = '0;
                        target_d = req_sel;
                        cnt_d    = CW'(DEAD);
                        state_d  = WAIT;
                    end
                end
            end
            default: begin
                en_d    = '0;
                asel_d  = '0;
                cnt_d   = '0;
                state_d = IDLE;
            end
        endcase
    end

    // Outputs: ready is low only while counting the dead gap.
    always_comb begin
        req_ready  = (state_q != WAIT);
        busy       = (state_q == WAIT);
        en         = en_q;
        active     = |en_q;
        active_sel = asel_q;
        err        = err_q;
    end

endmodule

// File: tb/tb_oh_clockmux_seq.sv
// Directed bench for oh_clockmux_seq (N=4, DEAD=2): reset, first select,
// switch with dead gap, same-channel, out-of-range and reset mid-switch.
module tb_oh_clockmux_seq;

    localparam int N    = 4;
    localparam int DEAD = 2;
    localparam int SW   = $clog2(N) + 1;

    logic          clk;
    logic          nreset;
    logic          req_valid;
    logic [SW-1:0] req_sel;
    logic          req_ready;
    logic [N-1:0]  en;
    logic          active;
    logic [SW-1:0] active_sel;
    logic          busy;
    logic          err;

    int errors = 0;
    int checks = 0;

    oh_clockmux_seq #(.N(N), .DEAD(DEAD)) dut (
        .clk        (clk),
        .nreset     (nreset),
        .req_valid  (req_valid),
        .req_sel    (req_sel),
        .req_ready  (req_ready),
        .en         (en),
        .active     (active),
        .active_sel (active_sel),
        .busy       (busy),
        .err        (err)
    );

    // Free-running reference clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Every cycle: en never multi-hot, and never jumps channel without a gap.
    logic [N-1:0] prevEn = '0;
    always @(negedge clk) begin
        checks++;
        assert ($onehot0(en)) else begin
            errors++;
            $error("[TB] FAIL onehot: en=%b required at most one bit set", en);
        end
        checks++;
        assert (!(prevEn != '0 && en != '0 && en !== prevEn)) else begin
            errors++;
            $error("[TB] FAIL gap: en=%b after %b, required an all-zero cycle between", en, prevEn);
        end
        prevEn = en;
    end

    task automatic step();
        @(negedge clk);
    endtask

    task automatic applyStimulus(input logic valid, input logic [SW-1:0] sel);
        req_valid = valid;
        req_sel   = sel;
    endtask

    task automatic checkVal(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic checkOutput(input string tag, input logic [N-1:0] expEn,
                               input logic expReady, input logic expErr,
                               input logic [SW-1:0] expAsel);
        checkVal({tag, ".en"}, 32'(en), 32'(expEn));
        checkVal({tag, ".ready"}, 32'(req_ready), 32'(expReady));
        checkVal({tag, ".busy"}, 32'(busy), 32'(!expReady));
        checkVal({tag, ".err"}, 32'(err), 32'(expErr));
        checkVal({tag, ".asel"}, 32'(active_sel), 32'(expAsel));
        checkVal({tag, ".active"}, 32'(active), 32'(expEn != '0));
    endtask

    // Directed sequence; inputs change on the falling edge, outputs checked there too.
    initial begin
        nreset = 1'b0;
        applyStimulus(1'b1, 3'd2);

        // Reset held with a pending request: nothing accepted.
        for (int i = 0; i < 3; i++) begin
            step();
            checkOutput("reset", 4'b0000, 1'b1, 1'b0, 3'd0);
        end

        // First select of channel 2 from IDLE.
        nreset = 1'b1;
        step();
        checkOutput("sel2_k", 4'b0000, 1'b0, 1'b0, 3'd0);
        applyStimulus(1'b0, 3'd0);
        step();
        checkOutput("sel2_k1", 4'b0000, 1'b0, 1'b0, 3'd0);
        step();
        checkOutput("sel2_on", 4'b0100, 1'b1, 1'b0, 3'd2);

        // Switch 2 -> 0 with a two-cycle gap; request held during WAIT is ignored.
        applyStimulus(1'b1, 3'd0);
        step();
        checkOutput("sw0_k", 4'b0000, 1'b0, 1'b0, 3'd0);
        applyStimulus(1'b1, 3'd3);
        step();
        checkOutput("sw0_k1", 4'b0000, 1'b0, 1'b0, 3'd0);
        applyStimulus(1'b0, 3'd0);
        step();
        checkOutput("sw0_on", 4'b0001, 1'b1, 1'b0, 3'd0);

        // Same-channel request: no change, no gap.
        applyStimulus(1'b1, 3'd0);
        step();
        checkOutput("same0", 4'b0001, 1'b1, 1'b0, 3'd0);
        applyStimulus(1'b0, 3'd0);
        step();
        checkOutput("same0_after", 4'b0001, 1'b1, 1'b0, 3'd0);

        // Out-of-range while ON: one-cycle err, en unchanged.
        applyStimulus(1'b1, 3'd5);
        step();
        checkOutput("oor_on", 4'b0001, 1'b1, 1'b1, 3'd0);
        applyStimulus(1'b0, 3'd0);
        step();
        checkOutput("oor_on_after", 4'b0001, 1'b1, 1'b0, 3'd0);

        // Reset one cycle into a switch: back to IDLE immediately.
        applyStimulus(1'b1, 3'd1);
        step();
        checkOutput("sw1_k", 4'b0000, 1'b0, 1'b0, 3'd0);
        applyStimulus(1'b0, 3'd0);
        nreset = 1'b0;
        step();
        checkOutput("rst_wait", 4'b0000, 1'b1, 1'b0, 3'd0);
        nreset = 1'b1;
        step();
        checkOutput("idle_after_rst", 4'b0000, 1'b1, 1'b0, 3'd0);

        // Out-of-range in IDLE, then select channel 3.
        applyStimulus(1'b1, 3'd5);
        step();
        checkOutput("oor_idle", 4'b0000, 1'b1, 1'b1, 3'd0);
        applyStimulus(1'b1, 3'd3);
        step();
        checkOutput("sel3_k", 4'b0000, 1'b0, 1'b0, 3'd0);
        applyStimulus(1'b1, 3'd1);
        step();
        checkOutput("sel3_k1", 4'b0000, 1'b0, 1'b0, 3'd0);
        step();
        checkOutput("sel3_on", 4'b1000, 1'b1, 1'b0, 3'd3);
        applyStimulus(1'b0, 3'd0);
        step();
        checkOutput("sel3_hold", 4'b1000, 1'b1, 1'b0, 3'd3);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
